// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass and a per-register pending-write scoreboard.
module regfile_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rfw_enable,
   input  logic [ADDR_W-1:0] rfw_address3,
   input  logic [DATA_W-1:0] rfw_data3,
   input  logic [ADDR_W-1:0] rfr_address1,
   input  logic [ADDR_W-1:0] rfr_address2,
   output logic [DATA_W-1:0] rfr_data1,
   output logic [DATA_W-1:0] rfr_data2,
   output logic              rfr_busy1,
   output logic              rfr_busy2,
   input  logic              sb_reserve,
   input  logic [ADDR_W-1:0] sb_reserve_address,
   output logic [ADDR_W:0]   sb_count,
   input  logic [ADDR_W-1:0] dbg_address,
   output logic [DATA_W-1:0] dbg_data,
   output logic              dbg_busy
);

   localparam int NREGS    = 2**ADDR_W;
   localparam bit HAS_ZERO = (ZERO_REG != 0);
   localparam bit HAS_BYP  = (BYPASS != 0);

   logic [DATA_W-1:0] mem [NREGS];
   logic [NREGS-1:0]  busy;
   logic [NREGS-1:0]  busy_nxt;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_nxt;
   logic              wr_eff;
   logic              rsv_eff;
   logic              set_inc;
   logic              clr_dec;
   logic              byp_en;
   logic              byp_busy;

   // Register 0 is hard-wired when ZERO_REG is set: writes and reserves to it vanish.
   assign wr_eff  = rfw_enable && !(HAS_ZERO && rfw_address3 == '0);
   assign rsv_eff = sb_reserve && !(HAS_ZERO && sb_reserve_address == '0);

   // Count moves only on real busy transitions; a same-address write+reserve keeps the bit set.
   assign set_inc = rsv_eff && !busy[sb_reserve_address];
   assign clr_dec = wr_eff && busy[rfw_address3] &&
                    !(rsv_eff && sb_reserve_address == rfw_address3);

   always_comb begin
      busy_nxt = busy;
      if (wr_eff)  busy_nxt[rfw_address3]       = 1'b0;
      if (rsv_eff) busy_nxt[sb_reserve_address] = 1'b1;
      count_nxt = count + {{ADDR_W{1'b0}}, set_inc} - {{ADDR_W{1'b0}}, clr_dec};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
         busy  <= '0;
         count <= '0;
      end else begin
         if (wr_eff) mem[rfw_address3] <= rfw_data3;
         busy  <= busy_nxt;
         count <= count_nxt;
      end
   end

   // Forwarding is held off during reset so outputs read zero throughout.
   assign byp_en   = HAS_BYP && rst_n && wr_eff;
   assign byp_busy = rsv_eff && (sb_reserve_address == rfw_address3);

   function automatic logic [DATA_W:0] read_mux(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] stored_data,
      input logic              stored_busy,
      input logic              fwd,
      input logic [ADDR_W-1:0] fwd_addr,
      input logic [DATA_W-1:0] fwd_data,
      input logic              fwd_busy
   );
      if (HAS_ZERO && addr == '0)
         return '0;
      else if (fwd && addr == fwd_addr)
         return {fwd_busy, fwd_data};
      else
         return {stored_busy, stored_data};
   endfunction

   assign {rfr_busy1, rfr_data1} = read_mux(rfr_address1, mem[rfr_address1], busy[rfr_address1],
                                            byp_en, rfw_address3, rfw_data3, byp_busy);
   assign {rfr_busy2, rfr_data2} = read_mux(rfr_address2, mem[rfr_address2], busy[rfr_address2],
                                            byp_en, rfw_address3, rfw_data3, byp_busy);
   assign {dbg_busy, dbg_data}   = read_mux(dbg_address, mem[dbg_address], busy[dbg_address],
                                            1'b0, rfw_address3, rfw_data3, 1'b0);
   assign sb_count = count;

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the pipelined datapath. It provides two combinational read ports, one clocked write port, and an optional write-to-read bypass. A per-register pending-write scoreboard with an occupancy counter lets decode detect RAW hazards. All state clears on asynchronous reset, and a debug read port gives the debugger visibility of registers and busy bits.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; NREGS = 2**ADDR_W registers
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes, never becomes busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- rfw_enable  input  1  write strobe
- rfw_address3  input  ADDR_W  write address
- rfw_data3  input  DATA_W  write data
- rfr_address1, rfr_address2  input  ADDR_W  read addresses
- rfr_data1, rfr_data2  output  DATA_W  read data, combinational
- rfr_busy1, rfr_busy2  output  1  read register has a pending write
- sb_reserve  input  1  mark destination as pending (instruction issue)
- sb_reserve_address  input  ADDR_W  destination being reserved
- sb_count  output  ADDR_W+1  number of registers currently busy
- dbg_address  input  ADDR_W  debug read address
- dbg_data  output  DATA_W  debug read data (stored value, never bypassed)
- dbg_busy  output  1  busy bit of dbg_address

## Operation
- Storage: NREGS x DATA_W data array plus NREGS busy bits.
- Write: if rfw_enable, the rising edge stores rfw_data3 at rfw_address3 and clears busy[rfw_address3].
- Reserve: if sb_reserve, the rising edge sets busy[sb_reserve_address].
- Same edge, same address, reserve and write both active: data is written and busy ends at 1, because the new producer wins.
- Reserving a register that is already busy: busy stays 1 and sb_count is unchanged.
- Writing a register that is not busy: data is written and sb_count is unchanged.
- sb_count tracks the population of the busy bits exactly:
  - +1 on an effective 0->1 transition
  - -1 on an effective 1->0 transition
  - net 0 when both occur on different addresses in the same cycle
  - it never wraps, since at most NREGS (or NREGS-1 with ZERO_REG) registers can be busy
- ZERO_REG=1:
  - address 0 reads data 0 and busy 0 on every port, including debug
  - writes and reserves to address 0 are ignored
- Read port n:
  - if ZERO_REG and address is 0: data 0, busy 0
  - else if BYPASS, rfw_enable and address equals rfw_address3: data is rfw_data3; busy is 1 only if sb_reserve targets the same address this cycle, otherwise 0
  - else: stored data and stored busy bit
- BYPASS=0: reads return the stored value, so a same-address read sees the new value only after the edge.
- Reset (rst_n low, any time, asynchronous):
  - all data registers, all busy bits and sb_count clear to 0 immediately
  - rfw_enable and sb_reserve are ignored while rst_n is low
  - the bypass is gated off while rst_n is low, so every data and busy output reads 0 throughout reset
- Reset release: the first rising edge with rst_n high performs normal writes and reserves.

## Timing
- Write latency: 1 edge to the stored array; 0 cycles to read ports when BYPASS=1.
- Busy set latency: visible on rfr_busy*/dbg_busy the cycle after the sb_reserve edge.
- Busy clear latency: visible the cycle after the write edge. With BYPASS=1 the matching read port shows busy 0 in the write cycle itself.
- sb_count is registered and updates on the same edge as the busy bits.
- Read paths are purely combinational from address and stored state; there are no read-side enables.
- Output reset values: rfr_data1/2 = 0, rfr_busy1/2 = 0, sb_count = 0, dbg_data = 0, dbg_busy = 0.

## Test plan
- Reset mid-run:
  - stimulus: write 0xDEADBEEF to r5, reserve r7, assert rst_n low between edges
  - response: rfr_data1 (addr 5) = 0, rfr_busy (addr 7) = 0 and sb_count = 0 immediately, with no clock edge needed
- Bypass:
  - stimulus: BYPASS=1, rfw_enable=1, rfw_address3=3, rfw_data3=0x12345678, rfr_address2=3
  - response: rfr_data2 = 0x12345678 in the same cycle; with BYPASS=0 it stays at the old value until after the edge
- Zero register:
  - stimulus: write 0xFFFFFFFF to r0 and reserve r0
  - response: rfr_data1 (addr 0) = 0, rfr_busy1 = 0, sb_count = 0
- Scoreboard sequence:
  - stimulus: reserve r4, r9 and r4 again on consecutive edges, then write r9 while reserving r10
  - response: sb_count steps 1, 2, 2, then stays 2; busy r4 = 1, r9 = 0, r10 = 1
- Simultaneous reserve and write to r6 (r6 busy beforehand):
  - response: r6 data updated, busy r6 stays 1, sb_count unchanged
  - with BYPASS=1, rfr_busy for r6 = 1 in that cycle
- Fill:
  - stimulus: reserve r1..r31 on consecutive edges, then write all 31
  - response: sb_count reaches 31 (ZERO_REG=1), returns to 0, and dbg_data shows each written value
